// File: rtl/core_sequencer_pkg.sv
// Shared constants for the multi-cycle core sequencer: FSM state encodings and trap causes.
package core_sequencer_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_TRAP    = 3'd5;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback and trap
// control around an external decoder, ALU and register file.
module core_sequencer
  import core_sequencer_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_is_writeback,
  input  logic            dec_is_jump,
  input  logic            dec_is_branch,
  input  logic            dec_illegal,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] alu_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_ack,
  output logic            reg_we,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap,
  output logic [XLEN-1:0] mepc,
  output logic [3:0]      mcause,
  output logic [2:0]      state
);

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_mepc;
  logic [3:0]      r_mcause;
  logic            w_taken;
  logic            w_misaligned;
  logic [3:0]      w_trap_cause;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_taken      = dec_is_jump | (dec_is_branch & branch_taken);
  assign w_misaligned = w_taken & (alu_out[1:0] != 2'b00);
  assign w_target     = {alu_out[XLEN-1:2], 2'b00};
  assign w_pc_plus4   = r_pc + XLEN'(4);
  // The decoder flags stay valid for inst until the next fetch, so the cause
  // can be rebuilt in TRAP instead of being held in a separate register.
  assign w_trap_cause = dec_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:   if (imem_ack) w_next_state = ST_DECODE;
      ST_DECODE:  w_next_state = dec_illegal ? ST_TRAP : ST_EXECUTE;
      ST_EXECUTE: begin
        if (dec_is_load | dec_is_store) w_next_state = ST_MEM;
        else if (w_misaligned)          w_next_state = ST_TRAP;
        else                            w_next_state = ST_WB;
      end
      ST_MEM:     if (dmem_ack) w_next_state = ST_WB;
      ST_WB:      w_next_state = ST_FETCH;
      ST_TRAP:    w_next_state = ST_FETCH;
      default:    w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_FETCH;
      r_pc     <= RESET_PC;
      r_inst   <= '0;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH && imem_ack) r_inst <= imem_rdata;
      if (r_state == ST_WB) r_pc <= w_taken ? w_target : w_pc_plus4;
      if (r_state == ST_TRAP) begin
        r_mepc   <= r_pc;
        r_mcause <= w_trap_cause;
        r_pc     <= TRAP_VEC;
      end
    end
  end

  // Handshake: a request is the state itself, so req stays high and addr/we stay
  // stable until ack; an ack is only acted on in the state that owns the request.
  // imem_req is masked by reset because the reset state is FETCH.
  assign imem_req  = rst & (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign dmem_req  = (r_state == ST_MEM);
  assign dmem_we   = (r_state == ST_MEM) & dec_is_store;
  assign dmem_addr = alu_out;
  assign reg_we    = (r_state == ST_WB) & dec_is_writeback;
  assign trap      = (r_state == ST_TRAP);
  assign inst      = r_inst;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign mepc      = r_mepc;
  assign mcause    = r_mcause;
  assign state     = r_state;

endmodule
